// File: rtl/xor_frame_sequencer.sv
// xor_frame_sequencer: assembles 6-byte frames into a/b/c operands for the
// 3-input XOR network and returns its pipelined result over valid/ready.
module xor_frame_sequencer #(
  parameter int unsigned LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic signed [15:0] a,
  output logic signed [15:0] b,
  output logic signed [15:0] c,
  input  logic signed [15:0] net_result,
  output logic [15:0]        out_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               frame_err,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_DRAIN,
    S_WAIT,
    S_OUT
  } state_e;

  state_e state_q, state_d;

  logic [2:0]      cnt_q, cnt_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [5:0][7:0] shadow_q, shadow_d;
  logic [15:0]     a_q, a_d;
  logic [15:0]     b_q, b_d;
  logic [15:0]     c_q, c_d;
  logic [15:0]     res_q, res_d;
  logic            ov_q, ov_d;
  logic            err_q, err_d;

  logic accept;
  logic load;
  logic last_slot;
  logic commit;
  logic bad;
  logic capture;
  logic release_out;

  assign accept      = in_valid && in_ready;
  assign load        = (state_q == S_LOAD) && accept;
  assign last_slot   = (cnt_q == 3'd5);
  assign commit      = load && last_slot && in_last;
  // in_last on the wrong slot, or no in_last on slot 5
  assign bad         = load && (last_slot != in_last);
  assign capture     = (state_q == S_WAIT) && (wcnt_q == 4'd0);
  assign release_out = (state_q == S_OUT) && ov_q && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD: begin
        if (accept && last_slot) begin
          state_d = in_last ? S_WAIT : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (accept && in_last) begin
          state_d = S_LOAD;
        end
      end
      S_WAIT: begin
        if (capture) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (release_out) begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      S_LOAD:  in_ready = 1'b1;
      S_DRAIN: in_ready = 1'b1;
      S_WAIT:  busy     = 1'b1;
      S_OUT:   busy     = 1'b1;
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      wcnt_q   <= '0;
      shadow_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      res_q    <= '0;
      ov_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      shadow_q <= shadow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      res_q    <= res_d;
      ov_q     <= ov_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    shadow_d = shadow_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    res_d    = res_q;
    ov_d     = ov_q;
    err_d    = bad;

    if (load) begin
      shadow_d[cnt_q] = in_data;
      cnt_d = (in_last || last_slot) ? 3'd0 : cnt_q + 3'd1;
    end

    // the final byte bypasses the shadow so commit lands on the same edge
    unique case (1'b1)
      commit: begin
        a_d    = {shadow_q[1], shadow_q[0]};
        b_d    = {shadow_q[3], shadow_q[2]};
        c_d    = {in_data, shadow_q[4]};
        wcnt_d = 4'(LATENCY);
      end
      capture: begin
        res_d = net_result;
        ov_d  = 1'b1;
      end
      release_out: begin
        ov_d = 1'b0;
      end
      default: begin
        if (state_q == S_WAIT) begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
    endcase
  end

  assign a          = a_q;
  assign b          = b_q;
  assign c          = c_q;
  assign out_result = res_q;
  assign out_valid  = ov_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_xor_frame_sequencer.sv
// Bench for xor_frame_sequencer: two instances (LATENCY 2 and 1) on shared
// stimulus, each fed by a delay-line model of the XOR network.
module tb_xor_frame_sequencer;

  localparam logic [15:0] KEY = 16'h0100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;

  logic               rdy0, rdy1;
  logic signed [15:0] a0, b0, c0, a1, b1, c1;
  logic signed [15:0] net0, net1;
  logic [15:0]        res0, res1;
  logic               ov0, ov1, err0, err1, busy0, busy1;

  xor_frame_sequencer #(.LATENCY(2)) u0 (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy0),
    .a(a0), .b(b0), .c(c0),
    .net_result(net0),
    .out_result(res0), .out_valid(ov0), .out_ready(out_ready),
    .frame_err(err0), .busy(busy0)
  );

  xor_frame_sequencer #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy1),
    .a(a1), .b(b1), .c(c1),
    .net_result(net1),
    .out_result(res1), .out_valid(ov1), .out_ready(out_ready),
    .frame_err(err1), .busy(busy1)
  );

  // network model: result = a^b^c^KEY, delayed by the pipeline depth
  logic [15:0] p0 [2] = '{16'h0, 16'h0};
  logic [15:0] p1 = 16'h0;
  always @(posedge clk) begin
    p0[0] <= a0 ^ b0 ^ c0 ^ KEY;
    p0[1] <= p0[0];
    p1    <= a1 ^ b1 ^ c1 ^ KEY;
  end
  assign net0 = p0[1];
  assign net1 = p1;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] ma = 16'h0;
  logic [15:0] mb = 16'h0;
  logic [15:0] mc = 16'h0;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b1;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!(rdy0 && rdy1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      vectors++;
      miscompares++;
      $error("FAIL accept_timeout: observed in_ready %b/%b expected 1", rdy0, rdy1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_a0"}, a0, ma);
    check({tag, "_b0"}, b0, mb);
    check({tag, "_c0"}, c0, mc);
    check({tag, "_a1"}, a1, ma);
    check({tag, "_rdy0"}, rdy0, 1'b1);
    check({tag, "_busy0"}, busy0, 1'b0);
    check({tag, "_ov0"}, ov0, 1'b0);
    check({tag, "_ov1"}, ov1, 1'b0);
  endtask

  task automatic send_six(input logic [15:0] va, vb, vc, input int gap);
    logic [7:0] fr [6];
    fr[0] = va[7:0]; fr[1] = va[15:8];
    fr[2] = vb[7:0]; fr[3] = vb[15:8];
    fr[4] = vc[7:0]; fr[5] = vc[15:8];
    for (int i = 0; i < 6; i++) send(fr[i], i == 5, gap);
  endtask

  task automatic good_frame(input logic [15:0] va, vb, vc,
                            input int gap, input int hold);
    logic [15:0] exp;
    send_six(va, vb, vc, gap);
    ma = va; mb = vb; mc = vc;
    exp = va ^ vb ^ vc ^ KEY;
    check("commit_a0", a0, ma);
    check("commit_b0", b0, mb);
    check("commit_c0", c0, mc);
    check("commit_c1", c1, mc);
    check("wait_rdy0", rdy0, 1'b0);
    check("wait_busy0", busy0, 1'b0 | 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check("ov1_timing", ov1, k >= 2);
      check("ov0_timing", ov0, k >= 3);
      check("wait_rdy1", rdy1, 1'b0);
      if (k >= 2) check("res1", res1, exp);
      if (k == 3) check("res0", res0, exp);
    end
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("hold_res0", res0, exp);
      check("hold_res1", res1, exp);
      check("hold_ov0", ov0, 1'b1);
      check("hold_rdy0", rdy0, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("hs_ov0", ov0, 1'b0);
    check("hs_ov1", ov1, 1'b0);
    check("hs_rdy0", rdy0, 1'b1);
    check("hs_rdy1", rdy1, 1'b1);
    check("hs_busy0", busy0, 1'b0);
  endtask

  task automatic bad_frame(input int len, input int gap);
    int errat;
    errat = (len < 6) ? len - 1 : 5;
    for (int i = 0; i < len; i++) begin
      send(8'($urandom), i == len - 1, gap);
      check("err0_pulse", err0, i == errat);
      check("err1_pulse", err1, i == errat);
    end
    check_idle("bad");
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bad_err_low", err0, 1'b0);
      check("bad_no_ov", ov0, 1'b0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    ma = 16'h0; mb = 16'h0; mc = 16'h0;
    check("rst_res0", res0, 16'h0);
    check("rst_res1", res1, 16'h0);
    check("rst_err0", err0, 1'b0);
    check_idle("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $error("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra, rb, rc;
    int          lens [5];
    lens = '{2, 4, 5, 7, 8};
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_res0", res0, 16'h0);
    check("reset_err0", err0, 1'b0);
    check("reset_busy1", busy1, 1'b0);
    check_idle("reset");
    rst = 1'b0;

    // nominal frame 00 01 00 00 00 01
    good_frame(16'h0100, 16'h0000, 16'h0100, 0, 0);

    // output backpressure
    good_frame(16'(($urandom)), 16'(($urandom)), 16'(($urandom)), 0, 10);

    // short frame then recovery
    bad_frame(4, 0);
    good_frame(16'h0080, 16'hFF80, 16'h0000, 0, 0);

    // long frame then recovery
    bad_frame(8, 0);
    good_frame(16'h1234, 16'h5678, 16'h9ABC, 0, 1);

    // reset during WAIT
    send_six(16'h7F01, 16'h0203, 16'h0405, 0);
    @(posedge clk);
    #1;
    pulse_reset();
    good_frame(16'hBEEF, 16'hCAFE, 16'h0F0F, 0, 0);

    // reset after 3 bytes of a frame
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0, 0);
    pulse_reset();
    good_frame(16'h0A0B, 16'h0C0D, 16'h0E0F, 0, 0);

    // gapped input
    good_frame(16'(($urandom)), 16'(($urandom)), 16'(($urandom)), 1, 2);

    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        bad_frame(lens[$urandom_range(0, 4)], $urandom_range(0, 1));
      end
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 16'($urandom);
      good_frame(ra, rb, rc, $urandom_range(0, 1), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
